// File: rtl/sid_pkg.sv
// Shared constants for the parametrised SID register bank: per-voice register
// indices and the filter / read-only offsets relative to the filter base.
package sid_pkg;
  localparam int REGS_PER_VOICE = 7;
  localparam int FILTER_REGS    = 4;
  localparam int READ_REGS      = 4;

  localparam int R_FREQ_LO = 0;
  localparam int R_FREQ_HI = 1;
  localparam int R_PW_LO   = 2;
  localparam int R_PW_HI   = 3;
  localparam int R_CONTROL = 4;
  localparam int R_ATT_DEC = 5;
  localparam int R_SUS_REL = 6;

  localparam int OFF_FC_LO    = 0;
  localparam int OFF_FC_HI    = 1;
  localparam int OFF_RES_FILT = 2;
  localparam int OFF_MODE_VOL = 3;
  localparam int OFF_POTX     = 4;
  localparam int OFF_POTY     = 5;
  localparam int OFF_OSC      = 6;
  localparam int OFF_ENV      = 7;

  function automatic int filt_base(input int num_voices);
    return num_voices * REGS_PER_VOICE;
  endfunction
endpackage

// File: rtl/sid_bus_decay.sv
// Open-bus latch: holds the last bus value and clears it after DECAY_TICKS
// idle ce_1m ticks; the counter saturates until the next load.
module sid_bus_decay #(
  parameter int DECAY_TICKS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_1m,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value
);
  localparam int CW = $clog2(DECAY_TICKS + 1);
  localparam logic [CW-1:0] TERM = CW'(DECAY_TICKS);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      value <= '0;
    end else if (load) begin
      cnt   <= '0;
      value <= load_val;
    end else if (ce_1m && cnt != TERM) begin
      cnt <= cnt + 1'b1;
      if (cnt == TERM - 1'b1) value <= '0;
    end
  end
endmodule

// File: rtl/sid_regbank_n.sv
// SID register bank for NUM_VOICES voices: write decode into flattened voice and
// filter buses, registered readback of POTX/POTY/OSC/ENV, and an open-bus latch.
module sid_regbank_n import sid_pkg::*; #(
  parameter int NUM_VOICES  = 3,
  parameter int DECAY_TICKS = 2000,
  parameter int READ_VOICE  = NUM_VOICES - 1,
  parameter int ADDR_W      = $clog2(NUM_VOICES*REGS_PER_VOICE + FILTER_REGS + READ_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_1m,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  input  logic [NUM_VOICES*8-1:0]  osc_in,
  input  logic [NUM_VOICES*8-1:0]  env_in,
  input  logic [7:0]               pot_x,
  input  logic [7:0]               pot_y,
  output logic [NUM_VOICES*16-1:0] freq,
  output logic [NUM_VOICES*12-1:0] pw,
  output logic [NUM_VOICES*8-1:0]  control,
  output logic [NUM_VOICES*8-1:0]  att_dec,
  output logic [NUM_VOICES*8-1:0]  sus_rel,
  output logic [NUM_VOICES-1:0]    ctrl_wr,
  output logic [7:0]               fc_lo,
  output logic [7:0]               fc_hi,
  output logic [7:0]               res_filt,
  output logic [7:0]               mode_vol
);
  localparam int F = filt_base(NUM_VOICES);

  logic       rd_en, rd_hit, bus_load;
  logic [7:0] rd_val, last_wr, load_val;
  logic       unused_bits;

  assign rd_en = re & ~we;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    localparam int BASE = v * REGS_PER_VOICE;
    logic [REGS_PER_VOICE-1:0] sel;
    logic [7:0] f_lo, f_hi, p_lo, ctl, ad, sr;
    logic [3:0] p_hi;
    logic       ctl_pulse;

    always_comb begin
      sel = '0;
      for (int r = 0; r < REGS_PER_VOICE; r++)
        sel[r] = we && (addr == ADDR_W'(BASE + r));
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        f_lo <= '0; f_hi <= '0; p_lo <= '0; p_hi <= '0;
        ctl  <= '0; ad   <= '0; sr   <= '0; ctl_pulse <= 1'b0;
      end else begin
        if (sel[R_FREQ_LO]) f_lo <= data_in;
        if (sel[R_FREQ_HI]) f_hi <= data_in;
        if (sel[R_PW_LO])   p_lo <= data_in;
        if (sel[R_PW_HI])   p_hi <= data_in[3:0];
        if (sel[R_CONTROL]) ctl  <= data_in;
        if (sel[R_ATT_DEC]) ad   <= data_in;
        if (sel[R_SUS_REL]) sr   <= data_in;
        ctl_pulse <= sel[R_CONTROL];
      end
    end

    assign freq[16*v +: 16]   = {f_hi, f_lo};
    assign pw[12*v +: 12]     = {p_hi, p_lo};
    assign control[8*v +: 8]  = ctl;
    assign att_dec[8*v +: 8]  = ad;
    assign sus_rel[8*v +: 8]  = sr;
    assign ctrl_wr[v]         = ctl_pulse;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_lo <= '0; fc_hi <= '0; res_filt <= '0; mode_vol <= '0;
    end else if (we) begin
      if (addr == ADDR_W'(F + OFF_FC_LO))    fc_lo    <= data_in;
      if (addr == ADDR_W'(F + OFF_FC_HI))    fc_hi    <= data_in;
      if (addr == ADDR_W'(F + OFF_RES_FILT)) res_filt <= data_in;
      if (addr == ADDR_W'(F + OFF_MODE_VOL)) mode_vol <= data_in;
    end
  end

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (int'(addr))
      F + OFF_POTX: rd_val = pot_x;
      F + OFF_POTY: rd_val = pot_y;
      F + OFF_OSC:  rd_val = osc_in[8*READ_VOICE +: 8];
      F + OFF_ENV:  rd_val = env_in[8*READ_VOICE +: 8];
      default:      rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      data_out <= '0;
    else if (rd_en) data_out <= rd_hit ? rd_val : last_wr;
  end

  // Reads of write-only/unmapped addresses pause the decay but do not restart it.
  assign bus_load = we | (rd_en & rd_hit);
  assign load_val = we ? data_in : rd_val;

  sid_bus_decay #(.DECAY_TICKS(DECAY_TICKS)) u_decay (
    .clk      (clk),
    .reset    (reset),
    .ce_1m    (ce_1m & ~(we | re)),
    .load     (bus_load),
    .load_val (load_val),
    .value    (last_wr)
  );

  assign unused_bits = ^{osc_in, env_in};
endmodule

// File: tb/tb_sid_regbank_n.sv
// Directed bench for sid_regbank_n: a 3-voice and a 5-voice instance, both
// with a short decay time, driven by a linear sequence of steps.
module tb_sid_regbank_n;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce_1m = 1'b0;
  always #5 clk = ~clk;

  // 3-voice instance
  logic        a_we = 0, a_re = 0;
  logic [4:0]  a_addr = '0;
  logic [7:0]  a_din = '0, a_dout, a_potx = '0, a_poty = '0;
  logic [23:0] a_osc = '0, a_env = '0;
  logic [47:0] a_freq;
  logic [35:0] a_pw;
  logic [23:0] a_ctl, a_ad, a_sr;
  logic [2:0]  a_cwr;
  logic [7:0]  a_fcl, a_fch, a_rf, a_mv;

  // 5-voice instance
  logic        b_we = 0, b_re = 0;
  logic [5:0]  b_addr = '0;
  logic [7:0]  b_din = '0, b_dout, b_potx = '0, b_poty = '0;
  logic [39:0] b_osc = '0, b_env = '0;
  logic [79:0] b_freq;
  logic [59:0] b_pw;
  logic [39:0] b_ctl, b_ad, b_sr;
  logic [4:0]  b_cwr;
  logic [7:0]  b_fcl, b_fch, b_rf, b_mv;

  int tests = 0;
  int fails = 0;

  sid_regbank_n #(.NUM_VOICES(3), .DECAY_TICKS(4)) dut_a (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .we(a_we), .re(a_re), .addr(a_addr),
    .data_in(a_din), .data_out(a_dout), .osc_in(a_osc), .env_in(a_env),
    .pot_x(a_potx), .pot_y(a_poty), .freq(a_freq), .pw(a_pw), .control(a_ctl),
    .att_dec(a_ad), .sus_rel(a_sr), .ctrl_wr(a_cwr), .fc_lo(a_fcl), .fc_hi(a_fch),
    .res_filt(a_rf), .mode_vol(a_mv));

  sid_regbank_n #(.NUM_VOICES(5), .DECAY_TICKS(4)) dut_b (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .we(b_we), .re(b_re), .addr(b_addr),
    .data_in(b_din), .data_out(b_dout), .osc_in(b_osc), .env_in(b_env),
    .pot_x(b_potx), .pot_y(b_poty), .freq(b_freq), .pw(b_pw), .control(b_ctl),
    .att_dec(b_ad), .sus_rel(b_sr), .ctrl_wr(b_cwr), .fc_lo(b_fcl), .fc_hi(b_fch),
    .res_filt(b_rf), .mode_vol(b_mv));

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    a_we = 0; a_re = 0; b_we = 0; b_re = 0; ce_1m = 0;
  endtask

  task automatic wr(input bit b, input int adr, input logic [7:0] d);
    if (b) begin b_we = 1; b_addr = 6'(adr); b_din = d; end
    else   begin a_we = 1; a_addr = 5'(adr); a_din = d; end
    step();
  endtask

  task automatic rd(input bit b, input int adr);
    if (b) begin b_re = 1; b_addr = 6'(adr); end
    else   begin a_re = 1; a_addr = 5'(adr); end
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ce_1m = 1;
      step();
    end
  endtask

  initial begin
    a_potx = 8'h5A;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // reset state and POTX readback
    chk("rst_freq", a_freq, 0);
    chk("rst_pw", a_pw, 0);
    chk("rst_ctl", a_ctl, 0);
    chk("rst_mv", a_mv, 0);
    chk("rst_cwr", a_cwr, 0);
    chk("rst_dout", a_dout, 0);
    rd(0, 'h19);
    chk("potx", a_dout, 8'h5A);

    // frequency / pulse width / control decode
    wr(0, 'h01, 8'h12);
    wr(0, 'h00, 8'h34);
    wr(0, 'h03, 8'hF7);
    chk("freq0", a_freq[15:0], 16'h1234);
    chk("pw0", a_pw[11:0], 12'h700);
    wr(0, 'h0B, 8'h41);
    chk("ctl1", a_ctl[15:8], 8'h41);
    chk("cwr_pulse", a_cwr, 3'b010);
    step();
    chk("cwr_clear", a_cwr, 3'b000);
    chk("freq1_untouched", a_freq[31:16], 16'h0000);

    // open-bus latch and decay
    wr(0, 'h04, 8'hA5);
    rd(0, 'h04);
    chk("openbus", a_dout, 8'hA5);
    ticks(3);
    rd(0, 'h04);
    chk("decay_early", a_dout, 8'hA5);
    ticks(4);
    rd(0, 'h04);
    chk("decay_done", a_dout, 8'h00);
    chk("ctl0_kept", a_ctl[7:0], 8'hA5);

    // 5-voice map
    wr(1, 'h26, 8'h1F);
    chk("b_modevol", b_mv, 8'h1F);
    chk("b_fclo", b_fcl, 8'h00);
    b_osc = 40'hC3_44_33_22_11;
    b_env = 40'h9E_01_02_03_04;
    rd(1, 'h29);
    chk("b_osc", b_dout, 8'hC3);
    rd(1, 'h2A);
    chk("b_env", b_dout, 8'h9E);
    wr(1, 'h20, 8'h81);
    chk("b_ctl4", b_ctl[39:32], 8'h81);
    chk("b_cwr", b_cwr, 5'b10000);

    // concurrent we and re to a read-only address
    a_osc = 24'hEE_22_11;
    rd(0, 'h19);
    chk("potx2", a_dout, 8'h5A);
    a_we = 1; a_re = 1; a_addr = 5'h1B; a_din = 8'h77;
    step();
    chk("wr_rd_dout_hold", a_dout, 8'h5A);
    chk("wr_rd_freq", a_freq, 48'h0000_0000_1234);
    chk("wr_rd_ctl", a_ctl, 24'h0041A5);
    chk("wr_rd_pw", a_pw, 36'h000000700);
    chk("wr_rd_mv", a_mv, 8'h00);
    rd(0, 'h00);
    chk("wr_rd_lastwr", a_dout, 8'h77);

    // reset mid-decay, and reset overriding a write
    wr(0, 'h02, 8'h66);
    ticks(3);
    reset = 1;
    step();
    reset = 0;
    chk("rst2_dout", a_dout, 8'h00);
    chk("rst2_pw", a_pw, 0);
    chk("rst2_ctl", a_ctl, 0);
    chk("rst2_b_mv", b_mv, 0);
    rd(0, 'h00);
    chk("rst2_lastwr", a_dout, 8'h00);
    reset = 1; a_we = 1; a_addr = 5'h05; a_din = 8'h12;
    step();
    reset = 0;
    chk("rst_over_we", a_ad, 0);
    rd(0, 'h00);
    chk("rst_over_lastwr", a_dout, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
